micro_seq: RTL and testbench

Microprogram sequencer for the microprogrammed-CPU experiment. It owns the micro-program counter (uPC) and drives the 8-bit address into the 256x24 control ROM. It generates the load strobe for the micro-instruction register and computes the next micro-address from the sequencing field of the word just read, the machine opcode and the datapath flags. It sits directly upstream of the ROM/micro-instruction-register pair and consumes the ROM output in the same loop.

---
 rtl/micro_seq.sv | 124 ++++++++++++
 tb/tb_micro_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_seq.sv
// rtl/micro_seq.sv - microprogram sequencer: uPC, control-ROM address, uIR load strobe
// Three-cycle FETCH/LOAD/EXEC loop with one-level CALL/RET and a sticky HALT.
module micro_seq #(
    parameter logic [7:0] RESET_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [23:0] rom_q,
    input  logic [3:0]  op,
    input  logic        flag_z,
    input  logic        flag_c,
    output logic [7:0]  uaddr,
    output logic        uir_ld,
    output logic        ustep,
    output logic        halted,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LOAD  = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [2:0] BM_NEXT = 3'd0;
    localparam logic [2:0] BM_JMP  = 3'd1;
    localparam logic [2:0] BM_JZ   = 3'd2;
    localparam logic [2:0] BM_JC   = 3'd3;
    localparam logic [2:0] BM_DISP = 3'd4;
    localparam logic [2:0] BM_CALL = 3'd5;
    localparam logic [2:0] BM_RET  = 3'd6;
    localparam logic [2:0] BM_HALT = 3'd7;

    state_t     state_q;
    logic [7:0] upc_q, upc_d;
    logic [7:0] ret_q, ret_d;
    logic       uir_ld_q, ustep_q, halted_q, busy_q;

    logic [2:0] bm;
    logic [7:0] na;
    logic [7:0] inc;
    logic       unused_rom;

    assign bm         = rom_q[10:8];
    assign na         = rom_q[7:0];
    assign inc        = upc_q + 8'd1;
    assign unused_rom = ^rom_q[23:11];

    // Next-address decode; only committed on the EXEC cycle, when rom_q holds the current word.
    always_comb begin
        upc_d = inc;
        ret_d = ret_q;
        case (bm)
            BM_NEXT: upc_d = inc;
            BM_JMP:  upc_d = na;
            BM_JZ:   upc_d = flag_z ? na : inc;
            BM_JC:   upc_d = flag_c ? na : inc;
            BM_DISP: upc_d = {na[7:4], op};
            BM_CALL: begin
                upc_d = na;
                ret_d = inc;
            end
            BM_RET:  upc_d = ret_q;
            BM_HALT: upc_d = upc_q;
            default: upc_d = inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            upc_q    <= RESET_ADDR;
            ret_q    <= 8'h00;
            uir_ld_q <= 1'b0;
            ustep_q  <= 1'b0;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            uir_ld_q <= 1'b0;
            ustep_q  <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (run) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // Strobes are registered, so they are raised one cycle ahead to land on EXEC.
                    state_q  <= S_EXEC;
                    uir_ld_q <= 1'b1;
                    ustep_q  <= 1'b1;
                    busy_q   <= 1'b1;
                end
                S_EXEC: begin
                    upc_q  <= upc_d;
                    ret_q  <= ret_d;
                    busy_q <= 1'b0;
                    if (bm == BM_HALT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_q  <= S_HALT;
                    halted_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign uaddr  = upc_q;
    assign uir_ld = uir_ld_q;
    assign ustep  = ustep_q;
    assign halted = halted_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_micro_seq.sv
// tb/tb_micro_seq.sv - self-checking bench for micro_seq against an instruction-level model
module tb_micro_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [23:0] rom_q;
    logic [3:0]  op;
    logic        flag_z;
    logic        flag_c;
    logic [7:0]  uaddr;
    logic        uir_ld;
    logic        ustep;
    logic        halted;
    logic        busy;

    micro_seq #(.RESET_ADDR(8'h00)) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .rom_q  (rom_q),
        .op     (op),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .uaddr  (uaddr),
        .uir_ld (uir_ld),
        .ustep  (ustep),
        .halted (halted),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Synchronous control ROM: address sampled on the clock edge, data valid the next cycle.
    logic [23:0] rom [256];
    always @(posedge clk) rom_q <= rom[uaddr];

    int n_checks = 0;
    int n_fail   = 0;

    int m_pc;
    int m_ret;
    bit m_halted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] mkword(input int bm, input int na);
        logic [31:0] r;
        logic [2:0]  b;
        logic [7:0]  a;
        r = $urandom;
        b = bm[2:0];
        a = na[7:0];
        return {r[12:0], b, a};
    endfunction

    function automatic int model_next(input int bm, input int na, input int pc,
                                      input int ret, input int opv, input int z, input int c);
        int inc;
        inc = (pc + 1) % 256;
        case (bm)
            0: return inc;
            1: return na;
            2: return (z != 0) ? na : inc;
            3: return (c != 0) ? na : inc;
            4: return (na / 16) * 16 + opv;
            5: return na;
            6: return ret;
            default: return pc;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        run = 1'($urandom);
        @(posedge clk); #1;
        rst = 1'b0;
        m_pc = 0;
        m_ret = 0;
        m_halted = 0;
        check("rst_uaddr", 32'(uaddr), 0);
        check("rst_uir_ld", 32'(uir_ld), 0);
        check("rst_ustep", 32'(ustep), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_busy", 32'(busy), 0);
    endtask

    // One full micro-instruction starting in FETCH; eop/ez/ec < 0 means random at EXEC.
    task automatic do_instr(input int eop, input int ez, input int ec);
        logic [23:0] w;
        int bm, na, opv, z, c, nxt;
        check("f_uaddr", 32'(uaddr), m_pc);
        check("f_uir_ld", 32'(uir_ld), 0);
        check("f_ustep", 32'(ustep), 0);
        check("f_busy", 32'(busy), 0);
        check("f_halted", 32'(halted), 0);
        run = 1'b1;
        op = 4'($urandom);
        flag_z = 1'($urandom);
        flag_c = 1'($urandom);
        @(posedge clk); #1;
        check("l_uaddr", 32'(uaddr), m_pc);
        check("l_busy", 32'(busy), 1);
        check("l_uir_ld", 32'(uir_ld), 0);
        check("l_ustep", 32'(ustep), 0);
        run = 1'($urandom);
        op = (eop >= 0) ? 4'h3 : 4'($urandom);
        flag_z = (ez >= 0) ? ~1'(ez) : 1'($urandom);
        flag_c = (ec >= 0) ? ~1'(ec) : 1'($urandom);
        @(posedge clk); #1;
        check("x_uaddr", 32'(uaddr), m_pc);
        check("x_uir_ld", 32'(uir_ld), 1);
        check("x_ustep", 32'(ustep), 1);
        check("x_busy", 32'(busy), 1);
        opv = (eop >= 0) ? eop : int'($urandom_range(15, 0));
        z = (ez >= 0) ? ez : int'($urandom_range(1, 0));
        c = (ec >= 0) ? ec : int'($urandom_range(1, 0));
        op = 4'(opv);
        flag_z = 1'(z);
        flag_c = 1'(c);
        w = rom[m_pc[7:0]];
        bm = int'(w[10:8]);
        na = int'(w[7:0]);
        nxt = model_next(bm, na, m_pc, m_ret, opv, z, c);
        if (bm == 5) m_ret = (m_pc + 1) % 256;
        if (bm == 7) m_halted = 1;
        else m_pc = nxt;
        @(posedge clk); #1;
        op = 4'($urandom);
        flag_z = 1'($urandom);
        flag_c = 1'($urandom);
        if (m_halted) begin
            check("h_halted", 32'(halted), 1);
            check("h_uaddr", 32'(uaddr), m_pc);
            check("h_busy", 32'(busy), 0);
            check("h_uir_ld", 32'(uir_ld), 0);
        end
    endtask

    task automatic hold_halt(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            run = 1'($urandom);
            op = 4'($urandom);
            flag_z = 1'($urandom);
            flag_c = 1'($urandom);
            @(posedge clk); #1;
            check("hold_uaddr", 32'(uaddr), m_pc);
            check("hold_halted", 32'(halted), 1);
            check("hold_uir_ld", 32'(uir_ld), 0);
            check("hold_ustep", 32'(ustep), 0);
        end
    endtask

    // Assert rst while in LOAD (phase 1) or EXEC (phase 2) of the instruction at m_pc.
    task automatic reset_mid(input int phase);
        run = 1'b1;
        @(posedge clk); #1;
        if (phase == 2) begin
            @(posedge clk); #1;
        end
        do_reset();
    endtask

    initial begin
        rst = 1'b0;
        run = 1'b0;
        op = 4'h0;
        flag_z = 1'b0;
        flag_c = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = mkword(0, 0);

        do_reset();
        rom[0] = mkword(0, 8'h99);
        rom[1] = mkword(0, 8'h12);
        rom[2] = mkword(0, 8'h77);
        for (int i = 0; i < 3; i++) do_instr(-1, -1, -1);
        check("seq_end", 32'(uaddr), 32'h03);

        rom[3] = mkword(1, 8'h10);
        do_instr(-1, -1, -1);
        rom[8'h10] = mkword(2, 8'h40);
        do_instr(-1, 1, -1);
        check("jz_taken", 32'(uaddr), 32'h40);
        rom[8'h40] = mkword(1, 8'h10);
        do_instr(-1, -1, -1);
        do_instr(-1, 0, -1);
        check("jz_not_taken", 32'(uaddr), 32'h11);

        rom[8'h11] = mkword(1, 8'h10);
        rom[8'h10] = mkword(3, 8'h40);
        do_instr(-1, -1, -1);
        do_instr(-1, -1, 1);
        check("jc_taken", 32'(uaddr), 32'h40);
        do_instr(-1, -1, -1);
        do_instr(-1, -1, 0);
        check("jc_not_taken", 32'(uaddr), 32'h11);

        rom[8'h11] = mkword(1, 8'h05);
        rom[8'h05] = mkword(4, 8'hA0);
        do_instr(-1, -1, -1);
        do_instr(7, -1, -1);
        check("dispatch", 32'(uaddr), 32'hA7);

        rom[8'hA7] = mkword(1, 8'h20);
        rom[8'h20] = mkword(5, 8'h80);
        rom[8'h80] = mkword(6, 8'h00);
        do_instr(-1, -1, -1);
        do_instr(-1, -1, -1);
        check("call", 32'(uaddr), 32'h80);
        do_instr(-1, -1, -1);
        check("ret", 32'(uaddr), 32'h21);

        rom[8'h21] = mkword(1, 8'hFF);
        rom[8'hFF] = mkword(0, 8'h3C);
        do_instr(-1, -1, -1);
        do_instr(-1, -1, -1);
        check("next_wrap", 32'(uaddr), 32'h00);
        rom[0] = mkword(1, 8'hFF);
        rom[8'hFF] = mkword(5, 8'h30);
        rom[8'h30] = mkword(6, 8'h5A);
        do_instr(-1, -1, -1);
        do_instr(-1, -1, -1);
        do_instr(-1, -1, -1);
        check("call_wrap_ret", 32'(uaddr), 32'h00);

        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op = 4'($urandom);
            @(posedge clk); #1;
            check("idle_uaddr", 32'(uaddr), 0);
            check("idle_uir_ld", 32'(uir_ld), 0);
            check("idle_busy", 32'(busy), 0);
        end

        rom[0] = mkword(1, 8'h33);
        rom[8'h33] = mkword(7, 8'h12);
        do_instr(-1, -1, -1);
        do_instr(-1, -1, -1);
        hold_halt(20);
        check("halt_addr", 32'(uaddr), 32'h33);
        do_reset();

        rom[0] = mkword(5, 8'h60);
        rom[8'h60] = mkword(1, 8'h55);
        do_instr(-1, -1, -1);
        reset_mid(2);
        check("mid_exec_rst", 32'(uaddr), 32'h00);
        rom[0] = mkword(6, 8'hEE);
        do_instr(-1, -1, -1);
        check("ret_after_rst", 32'(uaddr), 32'h00);

        for (int n = 0; n < 400; n++) begin
            int bm;
            bm = ($urandom_range(31, 0) == 0) ? 7 : int'($urandom_range(6, 0));
            rom[m_pc[7:0]] = mkword(bm, int'($urandom_range(255, 0)));
            if ($urandom_range(49, 0) == 0) begin
                reset_mid(int'($urandom_range(2, 1)));
            end else begin
                do_instr(-1, -1, -1);
                if (m_halted) begin
                    hold_halt(int'($urandom_range(4, 1)));
                    do_reset();
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
